// File: rtl/conv_pkg.sv
// Shared constants and helpers for the 3x3 convolution MAC stage:
// accumulator width, saturation bounds and per-frame result count.
package conv_pkg;

   localparam int TAPS = 9;

   // Nine products plus 4 guard bits: the sum can never overflow.
   function automatic int acc_w(input int data_w, input int coef_w);
      return data_w + coef_w + 4;
   endfunction

   function automatic longint sat_max(input int data_w);
      return (longint'(1) <<< (data_w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int data_w);
      return -(longint'(1) <<< (data_w - 1));
   endfunction

   // Windows per frame for a 3x3 stride-2 scan.
   function automatic int n_out(input int in_y, input int in_x);
      return ((in_y - 3) / 2 + 1) * ((in_x - 3) / 2 + 1);
   endfunction

endpackage

// File: rtl/conv_weight_bank.sv
// Double-buffered 3x3 kernel store. Coefficients stream into the shadow
// bank; a start-of-frame with a full shadow bank copies it to the active
// bank. The coefficient outputs bypass to the shadow bank during the
// committing cycle so a window sampled on that edge already sees the
// new kernel.
module conv_weight_bank
   import conv_pkg::*;
#(
   parameter int COEF_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sof,
   input  logic                     weight_load,
   input  logic signed [COEF_W-1:0] weight_in,
   output logic signed [COEF_W-1:0] coef_o [TAPS],
   output logic                     ready_eff_o,
   output logic                     weights_ready_o
);

   logic signed [COEF_W-1:0] shadow_q [TAPS];
   logic signed [COEF_W-1:0] active_q [TAPS];
   logic [3:0]               w_idx_q, w_idx_d;
   logic                     shadow_full_q, shadow_full_d;
   logic                     ready_q;
   logic                     commit;

   assign commit = sof && shadow_full_q;

   // Next-state for the write index and the shadow-full flag; a 9th write
   // landing in the committing cycle still marks the shadow bank full.
   always_comb begin
      w_idx_d       = w_idx_q;
      shadow_full_d = shadow_full_q;
      if (commit)
         shadow_full_d = 1'b0;
      if (weight_load) begin
         if (w_idx_q == 4'd8) begin
            w_idx_d       = 4'd0;
            shadow_full_d = 1'b1;
         end else begin
            w_idx_d = w_idx_q + 4'd1;
         end
      end
   end

   // Bank storage, write pointer and commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TAPS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         w_idx_q       <= '0;
         shadow_full_q <= 1'b0;
         ready_q       <= 1'b0;
      end else begin
         if (weight_load)
            shadow_q[w_idx_q] <= weight_in;
         if (commit) begin
            for (int i = 0; i < TAPS; i++)
               active_q[i] <= shadow_q[i];
            ready_q <= 1'b1;
         end
         w_idx_q       <= w_idx_d;
         shadow_full_q <= shadow_full_d;
      end
   end

   // Kernel seen by the multiplier stage, including the commit bypass.
   always_comb begin
      for (int i = 0; i < TAPS; i++)
         coef_o[i] = commit ? shadow_q[i] : active_q[i];
   end

   assign ready_eff_o     = ready_q || commit;
   assign weights_ready_o = ready_q;

endmodule

// File: rtl/conv3x3_mac.sv
// Four-stage pipelined 3x3 multiply-accumulate with fixed-point shift,
// saturation and a per-frame result counter. Accepts one window per cycle
// with no backpressure.
// Build option: define CONV3X3_RELU_EN to clamp negative results to zero.
module conv3x3_mac
   import conv_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int FRAC_BITS = 8,
   parameter int INPUT_Y   = 3,
   parameter int INPUT_X   = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sof,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] data_in_0,
   input  logic signed [DATA_W-1:0] data_in_1,
   input  logic signed [DATA_W-1:0] data_in_2,
   input  logic signed [DATA_W-1:0] data_in_3,
   input  logic signed [DATA_W-1:0] data_in_4,
   input  logic signed [DATA_W-1:0] data_in_5,
   input  logic signed [DATA_W-1:0] data_in_6,
   input  logic signed [DATA_W-1:0] data_in_7,
   input  logic signed [DATA_W-1:0] data_in_8,
   input  logic                     weight_load,
   input  logic signed [COEF_W-1:0] weight_in,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] data_out,
   output logic                     frame_done,
   output logic                     weights_ready,
   output logic [15:0]              out_count
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = acc_w(DATA_W, COEF_W);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(DATA_W));
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(DATA_W));
   localparam logic [15:0] N_OUT = 16'(n_out(INPUT_Y, INPUT_X));

   function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
      if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
      else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
      else                  return v[DATA_W-1:0];
   endfunction

   function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
`ifdef CONV3X3_RELU_EN
      return v[DATA_W-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   logic signed [DATA_W-1:0] win [TAPS];
   logic signed [COEF_W-1:0] coef [TAPS];
   logic                     ready_eff;

   assign win[0] = data_in_0;
   assign win[1] = data_in_1;
   assign win[2] = data_in_2;
   assign win[3] = data_in_3;
   assign win[4] = data_in_4;
   assign win[5] = data_in_5;
   assign win[6] = data_in_6;
   assign win[7] = data_in_7;
   assign win[8] = data_in_8;

   conv_weight_bank #(.COEF_W(COEF_W)) u_bank (
      .clk             (clk),
      .rst             (rst),
      .sof             (sof),
      .weight_load     (weight_load),
      .weight_in       (weight_in),
      .coef_o          (coef),
      .ready_eff_o     (ready_eff),
      .weights_ready_o (weights_ready)
   );

   logic signed [PROD_W-1:0] prod_p1_q [TAPS];
   logic signed [ACC_W-1:0]  row_p2_q [3];
   logic signed [ACC_W-1:0]  shf_p3_q;
   logic                     vld_p1_q, vld_p2_q, vld_p3_q;
   logic signed [DATA_W-1:0] data_out_q;
   logic                     out_valid_q, out_valid_d;
   logic                     frame_done_q, frame_done_d;
   logic [15:0]              cnt_q, cnt_d, cnt_base;

   // Datapath registers; only the valid bits below carry reset.
   always_ff @(posedge clk) begin
      // S1: nine products
      for (int i = 0; i < TAPS; i++)
         prod_p1_q[i] <= PROD_W'(win[i]) * PROD_W'(coef[i]);
      // S2: row sums
      for (int r = 0; r < 3; r++)
         row_p2_q[r] <= ACC_W'(prod_p1_q[3*r]) + ACC_W'(prod_p1_q[3*r+1])
                      + ACC_W'(prod_p1_q[3*r+2]);
      // S3: total and fixed-point shift (floor)
      shf_p3_q <= (row_p2_q[0] + row_p2_q[1] + row_p2_q[2]) >>> FRAC_BITS;
   end

   // Output counter: wraps the cycle after reaching N_OUT; sof clears it.
   always_comb begin
      cnt_base     = (cnt_q == N_OUT) ? 16'd0 : cnt_q;
      out_valid_d  = vld_p3_q && !sof;
      cnt_d        = cnt_base;
      frame_done_d = 1'b0;
      if (sof) begin
         cnt_d = 16'd0;
      end else if (out_valid_d) begin
         cnt_d        = cnt_base + 16'd1;
         frame_done_d = (cnt_base + 16'd1) == N_OUT;
      end
   end

   // Valid pipeline (sof flushes in-flight work), S4 output and counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q     <= 1'b0;
         vld_p2_q     <= 1'b0;
         vld_p3_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         data_out_q   <= '0;
         frame_done_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         vld_p1_q     <= in_valid && ready_eff;
         vld_p2_q     <= vld_p1_q && !sof;
         vld_p3_q     <= vld_p2_q && !sof;
         // S4: saturate, optional ReLU, output register
         out_valid_q  <= out_valid_d;
         if (vld_p3_q)
            data_out_q <= relu(sat(shf_p3_q));
         frame_done_q <= frame_done_d;
         cnt_q        <= cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign data_out   = data_out_q;
   assign frame_done = frame_done_q;
   assign out_count  = cnt_q;

endmodule

// File: doc/conv3x3_mac.md
# conv3x3_mac

Pipelined 3x3 multiply-accumulate stage that sits directly downstream of the 3x3 stride-2 line buffer. It consumes the nine-tap window and its `output_valid` strobe, and applies a runtime-loadable signed 3x3 kernel. It emits one fixed-point, saturated result per window, and counts results to flag end of frame. The stage has no backpressure: the line buffer free-runs, so this stage accepts a window on any cycle.

## Interface
- `data_width`, 16: signed window sample and output width.
- `weight_width`, 16: signed kernel coefficient width.
- `frac_bits`, 8: arithmetic right shift applied to the accumulator before saturation.
- `input_y`, 3: frame height in pixels; must match the line buffer.
- `input_x`, 3: frame width in pixels; must match the line buffer.

Ports:
- `clk` in 1: the single clock for the block.
- `rst` in 1: synchronous, active-high reset.
- `sof` in 1: start-of-frame pulse, the same signal that drives the line buffer.
- `in_valid` in 1: window valid; wired to the line buffer's `output_valid`.
- `data_in_0` .. `data_in_8` in `data_width` each: window taps, wired to `data_out_0..8`. Tap 0 is the oldest (top-left) sample.
- `weight_load` in 1: write strobe for one coefficient.
- `weight_in` in `weight_width`: coefficient value, taken in tap order 0..8.
- `out_valid` out 1: result valid, high for one cycle per result.
- `data_out` out `data_width`: convolution result.
- `frame_done` out 1: one-cycle pulse, coincident with the last result of a frame.
- `weights_ready` out 1: the active kernel is loaded.
- `out_count` out 16: number of results emitted in the current frame (debug).

## Operation
- **Result count.** N_OUT = ((input_y-3)/2+1) * ((input_x-3)/2+1).
- **Weight banks.** There are two 9-entry banks: shadow and active.
  - Each `weight_load` writes `weight_in` to shadow[w_idx] and increments w_idx.
  - After index 8 is written, w_idx wraps to 0 and `shadow_full` is set.
- **Kernel commit.** On `sof`, if `shadow_full` was already set at the start of that cycle:
  - active <= shadow;
  - `shadow_full` <= 0;
  - `weights_ready` <= 1.
- **sof coinciding with the 9th write.** The write lands in shadow and `shadow_full` sets. The commit waits for the next `sof`.
- **Windows without a kernel.** A window with `weights_ready`=0 is discarded: no `out_valid`, no count.
- **Arithmetic.**
  - Each product is signed, `data_width`+`weight_width` bits.
  - The sum of nine products is sign-extended by 4 bits (ACC_W = `data_width`+`weight_width`+4), so the sum cannot overflow.
  - The accumulator is arithmetic-shifted right by `frac_bits`; the shift truncates toward negative infinity.
  - The shifted value saturates to the signed `data_width` range [-2^(`data_width`-1), 2^(`data_width`-1)-1].
- **Frame counter.**
  - `out_count` increments on each `out_valid`.
  - When the count reaches N_OUT, `frame_done` pulses in the same cycle, and `out_count` wraps to 0 in the next cycle.
  - `sof` clears `out_count` and flushes every in-flight pipeline valid bit; the flushed results are never emitted.
- **Reset values.** `rst` clears all of the following to zero: both banks, w_idx, `shadow_full`, `weights_ready`, pipeline valids, `out_valid`, `data_out`, `frame_done`, `out_count`.

## Timing
- The pipeline has 4 register stages:
  - S1: nine products registered.
  - S2: three row sums.
  - S3: total, then shift.
  - S4: saturate, ReLU, output register.
- A window sampled at edge N appears with `out_valid`=1 after edge N+3, i.e. latency 4 cycles.
- Throughput is one window per cycle. Back-to-back `in_valid` yields back-to-back `out_valid`.
- The active bank is read only at S1. A commit at `sof` affects windows sampled at or after that edge.
- `weight_load` takes effect at the clock edge. `weights_ready` rises the cycle after the committing `sof`.
- `sof` and `in_valid` in the same cycle: the window is accepted into the freshly cleared pipeline, and the commit (if any) applies to it.

## Configuration
- `CONV3X3_RELU_EN`
  - Defined: S4 clamps negative saturated results to 0.
  - Undefined: signed results pass through unchanged.
  - Latency is identical in both builds.

## Structure
- A shared package `conv_pkg` holds:
  - ACC_W derivation;
  - the saturation min/max constants;
  - the N_OUT function of `input_y` and `input_x`.
- The single sub-module is `conv_weight_bank`. It contains the shadow/active registers, w_idx, `shadow_full` and the commit logic, and exports the nine active coefficients plus `weights_ready`.

## Test plan
- **Identity kernel.** Load weights {0,0,0,0,256,0,0,0,0}, `frac_bits`=8, then pulse `sof`. Drive window taps 1..9 → `data_out`=5, 4 cycles after `in_valid`.
- **Saturation.** Load all weights =32767 and all taps =32767 → `data_out`=32767. With all taps =-32768 → `data_out`=-32768, or 0 under `CONV3X3_RELU_EN`.
- **Shadow commit.** Reload the kernel mid-frame. The old kernel stays in use until the next `sof`. Pulse `sof` in the same cycle as the 9th write → no commit until the following `sof`.
- **Frame count.** `input_y`=`input_x`=7 with continuous windows → 9 results; `frame_done` on the 9th; `out_count` returns to 0.
- **Flush.** Pulse `sof` 2 cycles after a window → that result is never emitted, and `out_count`=0.
- **Reset mid-frame.** Assert `rst` with 3 windows in flight → all outputs 0 and `weights_ready`=0. Later windows produce no output until a kernel is reloaded and committed.
